// File: rtl/dpram_be_clr.sv
// Single-clock true dual-port byte-lane RAM with a hardware fill engine.
// Each byte lane is its own TDP slice; the top owns the clear FSM and the lane fan-out.

module dpram_be_clr_lane #(
  parameter int         WIDTHAD  = 10,
  parameter logic [7:0] FILL     = 8'h00,
  parameter int         RDW_MODE = 0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_busy,
  input  logic [WIDTHAD-1:0] i_clr_addr,
  input  logic               i_cen_a,
  input  logic               i_we_a,
  input  logic [WIDTHAD-1:0] i_addr_a,
  input  logic [7:0]         i_d_a,
  output logic [7:0]         o_q_a,
  input  logic               i_cen_b,
  input  logic               i_we_b,
  input  logic [WIDTHAD-1:0] i_addr_b,
  input  logic [7:0]         i_d_b,
  output logic [7:0]         o_q_b
);
  localparam int DEPTH   = 2**WIDTHAD;
  localparam bit RDW_NEW = (RDW_MODE != 0);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_q_a, r_q_b;
  logic       w_run, w_same, w_wa, w_wb_raw, w_wb;
  logic [7:0] w_qa_nxt, w_qb_nxt;

  assign w_run    = reset_n & ~i_busy;
  assign w_same   = (i_addr_a == i_addr_b);
  assign w_wa     = w_run & i_cen_a & i_we_a;
  assign w_wb_raw = w_run & i_cen_b & i_we_b;
  // Port A wins a same-address, same-lane write.
  assign w_wb     = w_wb_raw & ~(w_wa & w_same);

  always_comb begin
    w_qa_nxt = r_mem[i_addr_a];
    if (w_wa)                 w_qa_nxt = i_d_a;
    else if (w_wb && w_same)  w_qa_nxt = RDW_NEW ? i_d_b : r_mem[i_addr_a];
  end

  always_comb begin
    w_qb_nxt = r_mem[i_addr_b];
    if (w_wa && w_same)       w_qb_nxt = (w_wb_raw || RDW_NEW) ? i_d_a : r_mem[i_addr_b];
    else if (w_wb)            w_qb_nxt = i_d_b;
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (i_busy) begin
        r_mem[i_clr_addr] <= FILL;
      end else begin
        if (w_wa) r_mem[i_addr_a] <= i_d_a;
        if (w_wb) r_mem[i_addr_b] <= i_d_b;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_q_a <= '0;
      r_q_b <= '0;
    end else if (!i_busy) begin
      if (i_cen_a) r_q_a <= w_qa_nxt;
      if (i_cen_b) r_q_b <= w_qb_nxt;
    end
  end

  assign o_q_a = r_q_a;
  assign o_q_b = r_q_b;
endmodule

module dpram_be_clr #(
  parameter int         BYTES          = 2,
  parameter int         WIDTHAD        = 10,
  parameter int         CLEAR_ON_RESET = 1,
  parameter logic [7:0] FILL           = 8'h00,
  parameter int         RDW_MODE       = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear_req,
  output logic                 busy,
  input  logic                 cen_a,
  input  logic [BYTES-1:0]     wren_a,
  input  logic [WIDTHAD-1:0]   address_a,
  input  logic [8*BYTES-1:0]   data_a,
  output logic [8*BYTES-1:0]   q_a,
  input  logic                 cen_b,
  input  logic [BYTES-1:0]     wren_b,
  input  logic [WIDTHAD-1:0]   address_b,
  input  logic [8*BYTES-1:0]   data_b,
  output logic [8*BYTES-1:0]   q_b
);
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t              r_state, w_state_nxt;
  logic [WIDTHAD-1:0]  r_clr_addr;
  logic                w_busy;

  logic [BYTES-1:0][7:0] w_d_a, w_d_b, w_q_a, w_q_b;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= RST_STATE;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= (r_state == S_CLEAR) ? r_clr_addr + 1'b1 : '0;
    end
  end

  // A request arriving mid-sweep is dropped, never queued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clear_req)         w_state_nxt = S_CLEAR;
      S_CLEAR: if (&r_clr_addr)       w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_CLEAR);
  end

  assign busy  = w_busy;
  assign w_d_a = data_a;
  assign w_d_b = data_b;
  assign q_a   = w_q_a;
  assign q_b   = w_q_b;

  for (genvar l = 0; l < BYTES; l++) begin : g_lane
    dpram_be_clr_lane #(
      .WIDTHAD  (WIDTHAD),
      .FILL     (FILL),
      .RDW_MODE (RDW_MODE)
    ) u_lane (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_busy     (w_busy),
      .i_clr_addr (r_clr_addr),
      .i_cen_a    (cen_a),
      .i_we_a     (wren_a[l]),
      .i_addr_a   (address_a),
      .i_d_a      (w_d_a[l]),
      .o_q_a      (w_q_a[l]),
      .i_cen_b    (cen_b),
      .i_we_b     (wren_b[l]),
      .i_addr_b   (address_b),
      .i_d_b      (w_d_b[l]),
      .o_q_b      (w_q_b[l])
    );
  end
endmodule
